// File: rtl/myio_axil_slave.sv
// ----------------------------------------------------------------------------
// myio_axil_slave
//   AXI4-Lite responder for the myIO peripheral. Four 32-bit read/write
//   registers are decoded from ADDR[3:2]; ADDR[1:0] and the PROT inputs are
//   ignored. reg0 is mirrored on io_out, and every committed write raises a
//   one-cycle pulse on reg_wr_pulse for the targeted register.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data and response
//   S_AXI_AR* / S_AXI_R*              read address and data
//   io_out        copy of reg0
//   reg_wr_pulse  one-hot, one cycle, bit n = reg n committed
//   dbg_w_state   write FSM state (0 idle, 1 half, 2 response)
//   dbg_r_state   read FSM state  (0 idle, 1 response)
//
// Handshake rule: a beat transfers on a rising edge where VALID and READY are
// both high. The responder never lets a READY depend on the matching VALID,
// and once it raises BVALID/RVALID it holds the response stable until the
// corresponding BREADY/RREADY completes the beat.
// ----------------------------------------------------------------------------
module myio_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     io_out,
    output logic [3:0]                        reg_wr_pulse,
    output logic [1:0]                        dbg_w_state,
    output logic                              dbg_r_state
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_HALF = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            ready_en_q,  ready_en_d;
    w_state_t        w_state_q,   w_state_d;
    logic            aw_held_q,   aw_held_d;
    logic [1:0]      aw_idx_q,    aw_idx_d;
    logic            w_held_q,    w_held_d;
    logic [DW-1:0]   wdata_q,     wdata_d;
    logic [SW-1:0]   wstrb_q,     wstrb_d;
    logic [3:0]      wr_pulse_q,  wr_pulse_d;
    logic [DW-1:0]   regs_q [4];
    logic [DW-1:0]   regs_d [4];
    r_state_t        r_state_q,   r_state_d;
    logic [DW-1:0]   rdata_q,     rdata_d;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic bvalid;
    logic rvalid;
    logic awready;
    logic wready;
    logic arready;
    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic [1:0]    cm_idx;
    logic [DW-1:0] cm_data;
    logic [SW-1:0] cm_strb;

    assign bvalid  = (w_state_q == W_RESP);
    assign rvalid  = (r_state_q == R_RESP);
    assign awready = ready_en_q && !aw_held_q && !bvalid;
    assign wready  = ready_en_q && !w_held_q  && !bvalid;
    assign arready = ready_en_q && !rvalid;

    assign aw_hs = S_AXI_AWVALID && awready;
    assign w_hs  = S_AXI_WVALID  && wready;
    assign ar_hs = S_AXI_ARVALID && arready;

    // A write commits on the first edge where both halves are either already
    // held or transferring right now; the live bus value wins over the latch
    // only when that half has not been held yet.
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign cm_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign cm_data = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign cm_strb = w_held_q  ? wstrb_q  : S_AXI_WSTRB;

    // ------------------------------------------------------------------
    // Write channel and register file
    // ------------------------------------------------------------------
    always_comb begin
        ready_en_d = 1'b1;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_pulse_d = 4'b0000;
        regs_d     = regs_q;

        if (commit) begin
            aw_held_d          = 1'b0;
            w_held_d           = 1'b0;
            wr_pulse_d[cm_idx] = 1'b1;
            for (int k = 0; k < SW; k++) begin
                if (cm_strb[k]) begin
                    regs_d[cm_idx][8*k +: 8] = cm_data[8*k +: 8];
                end
            end
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE, W_HALF: begin
                if (commit) begin
                    w_state_d = W_RESP;
                end else if (aw_held_d || w_held_d) begin
                    w_state_d = W_HALF;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read channel: registers are sampled before this edge's write lands,
    // so a read colliding with a commit returns the old value.
    // ------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_RESP;
                    rdata_d   = regs_q[S_AXI_ARADDR[3:2]];
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en_q <= 1'b0;
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= 2'b00;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= regs_d[i];
            end
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign io_out        = regs_q[0];
    assign reg_wr_pulse  = wr_pulse_q;
    assign dbg_w_state   = w_state_q;
    assign dbg_r_state   = r_state_q;

    // Address byte-offset bits and protection attributes carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_myio_axil_slave.sv
// ----------------------------------------------------------------------------
// tb_myio_axil_slave
//   Self-checking bench for myio_axil_slave. A four-entry register model is
//   updated with plain byte-mask arithmetic on every committed write; reads
//   push the model value into exp_q and the response is compared on arrival.
// ----------------------------------------------------------------------------
module tb_myio_axil_slave;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] io_out;
    logic [3:0]  reg_wr_pulse;
    logic [1:0]  dbg_w_state;
    logic        dbg_r_state;

    myio_axil_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .io_out        (io_out),
        .reg_wr_pulse  (reg_wr_pulse),
        .dbg_w_state   (dbg_w_state),
        .dbg_r_state   (dbg_r_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard / model
    // ------------------------------------------------------------------
    int          total = 0;
    int          bad = 0;
    logic [31:0] model [4];
    logic [31:0] exp_q [$];

    function automatic void model_write(input logic [3:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        model[addr / 4] = (model[addr / 4] & ~mask) | (data & mask);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) model[i] = '0;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_done, w_done, aw_now, w_now;
        int cyc;
        logic [3:0] exp_p;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_p = 4'b0001 << (addr / 4);
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 60) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_now  = awvalid && awready;
            w_now   = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) aw_done = 1;
            if (w_now)  w_done = 1;
            cyc++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        total++;
        if (!(aw_done && w_done)) begin
            bad++;
            $display("FAIL wr_accept addr=%h: got aw=%0d w=%0d exp both accepted", addr, aw_done, w_done);
        end else begin
            model_write(addr, data, strb);
            total++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || reg_wr_pulse !== exp_p) begin
                bad++;
                $display("FAIL wr_commit addr=%h: got bvalid=%b bresp=%b pulse=%b exp 1 00 %b",
                         addr, bvalid, bresp, reg_wr_pulse, exp_p);
            end
            @(posedge clk); #1;
            total++;
            if (bvalid !== 1'b0 || reg_wr_pulse !== 4'b0000) begin
                bad++;
                $display("FAIL wr_done addr=%h: got bvalid=%b pulse=%b exp 0 0000", addr, bvalid, reg_wr_pulse);
            end
        end
        bready = 1'b0;
    endtask

    // Pops its expected value from exp_q; the caller pushes it first.
    task automatic axi_read(input logic [3:0] addr, input int ar_dly, input string name);
        bit done, ar_now;
        int cyc;
        logic [31:0] exp_v;
        exp_v = exp_q.pop_front();
        done = 0; cyc = 0;
        @(negedge clk);
        araddr = addr; rready = 1'b1;
        while (!done && cyc < 60) begin
            arvalid = (cyc >= ar_dly);
            ar_now  = arvalid && arready;
            @(posedge clk); #1;
            if (ar_now) done = 1;
            cyc++;
        end
        arvalid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_accept: got no AR handshake exp one", name);
        end else begin
            if (rvalid !== 1'b1 || rdata !== exp_v || rresp !== 2'b00) begin
                bad++;
                $display("FAIL %s: got rvalid=%b rdata=%h rresp=%b exp 1 %h 00", name, rvalid, rdata, rresp, exp_v);
            end
            @(posedge clk); #1;
            total++;
            if (rvalid !== 1'b0) begin
                bad++;
                $display("FAIL %s_release: got rvalid=%b exp 0", name, rvalid);
            end
        end
        rready = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        total++;
        if (bvalid !== 0 || rvalid !== 0 || rdata !== 0 || io_out !== 0 || reg_wr_pulse !== 0) begin
            bad++;
            $display("FAIL reset_outputs: got b=%b r=%b rdata=%h io=%h pulse=%b exp all 0",
                     bvalid, rvalid, rdata, io_out, reg_wr_pulse);
        end
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++;
            $display("FAIL reset_readies: got %b exp 000", {awready, wready, arready});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++;
            $display("FAIL ready_first_cycle: got %b exp 000", {awready, wready, arready});
        end
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++;
            $display("FAIL ready_enable: got %b exp 111", {awready, wready, arready});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model[i]);
            axi_read(4'(i * 4), 0, "basic_rd");
        end
        total++;
        if (io_out !== 32'd1) begin
            bad++;
            $display("FAIL basic_io_out: got %h exp 00000001", io_out);
        end
    endtask

    task automatic test_w_before_aw();
        @(negedge clk);
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bvalid !== 0 || wready !== 0 || reg_wr_pulse !== 0 || awready !== 1) begin
                bad++;
                $display("FAIL w_first_wait%0d: got b=%b wr=%b awr=%b pulse=%b exp 0 0 1 0000",
                         i, bvalid, wready, awready, reg_wr_pulse);
            end
            @(posedge clk); #1;
        end
        awaddr = 4'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        model_write(4'h8, 32'hDEADBEEF, 4'hF);
        total++;
        if (bvalid !== 1 || reg_wr_pulse !== 4'b0100) begin
            bad++;
            $display("FAIL w_first_commit: got b=%b pulse=%b exp 1 0100", bvalid, reg_wr_pulse);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        total++;
        if (bvalid !== 0 || reg_wr_pulse !== 4'b0000) begin
            bad++;
            $display("FAIL w_first_pulse_len: got b=%b pulse=%b exp 0 0000", bvalid, reg_wr_pulse);
        end
        exp_q.push_back(model[2]);
        axi_read(4'h8, 1, "w_first_rd");
    endtask

    task automatic test_strobe();
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_write(4'h4, 32'h00000000, 4'b0101, 1, 0);
        exp_q.push_back(32'hFF00FF00);
        axi_read(4'h4, 0, "strobe_rd");
        axi_write(4'h5, 32'h12345678, 4'b0000, 0, 2);
        exp_q.push_back(model[1]);
        axi_read(4'h6, 0, "strobe_none_rd");
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        awaddr = 4'h4; wdata = 32'hCAFE0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        model_write(4'h4, 32'hCAFE0001, 4'hF);
        awaddr = 4'hC; wdata = 32'h0BAD0BAD;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bvalid !== 1 || awready !== 0 || wready !== 0) begin
                bad++;
                $display("FAIL bp_hold%0d: got b=%b awr=%b wr=%b exp 1 0 0", i, bvalid, awready, wready);
            end
            @(posedge clk); #1;
        end
        // The second write is still being offered; it completes once B drains.
        axi_write(4'hC, 32'h0BAD0BAD, 4'hF, 0, 0);
        exp_q.push_back(model[1]);
        axi_read(4'h4, 0, "bp_rd1");
        exp_q.push_back(model[3]);
        axi_read(4'hC, 0, "bp_rd3");
    endtask

    task automatic test_collision();
        axi_write(4'h0, 32'h11, 4'hF, 0, 0);
        @(negedge clk);
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b0;
        awaddr = 4'h0; awvalid = 1'b1; araddr = 4'h0; arvalid = 1'b1;
        exp_q.push_back(model[0]);
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        model_write(4'h0, 32'h55, 4'hF);
        total++;
        if (rvalid !== 1 || rdata !== exp_q.pop_front() || bvalid !== 1) begin
            bad++;
            $display("FAIL collide_old: got r=%b rdata=%h b=%b exp 1 00000011 1", rvalid, rdata, bvalid);
        end
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        total++;
        if (rvalid !== 0 || bvalid !== 0 || io_out !== 32'h55) begin
            bad++;
            $display("FAIL collide_done: got r=%b b=%b io=%h exp 0 0 00000055", rvalid, bvalid, io_out);
        end
        exp_q.push_back(model[0]);
        axi_read(4'h0, 0, "collide_new");
    endtask

    task automatic test_back_to_back();
        int a;
        logic [31:0] exp_v;
        @(negedge clk);
        rready = 1'b1; arvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = (k / 2) % 4;
            araddr = 4'(a * 4);
            exp_v = model[a];
            @(posedge clk); #1;
            total++;
            if (k % 2 == 0) begin
                if (rvalid !== 1 || rdata !== exp_v) begin
                    bad++;
                    $display("FAIL b2b_rd%0d: got r=%b rdata=%h exp 1 %h", k, rvalid, rdata, exp_v);
                end
            end else if (rvalid !== 0) begin
                bad++;
                $display("FAIL b2b_gap%0d: got r=%b exp 0", k, rvalid);
            end
        end
        arvalid = 1'b0; rready = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  addr;
        logic [31:0] data;
        for (int n = 0; n < 40; n++) begin
            addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                axi_write(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                exp_q.push_back(model[addr / 4]);
                axi_read(addr, $urandom_range(0, 3), "rand_rd");
            end
            total++;
            if (io_out !== model[0]) begin
                bad++;
                $display("FAIL rand_io_out: got %h exp %h", io_out, model[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        total++;
        if (rvalid !== 1) begin
            bad++;
            $display("FAIL rst_mid_setup: got r=%b exp 1", rvalid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (rvalid !== 0 || bvalid !== 0 || io_out !== 0 || rdata !== 0 || {awready, wready, arready} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_clear: got r=%b b=%b io=%h rdata=%h rdy=%b exp 0 0 0 0 000",
                     rvalid, bvalid, io_out, rdata, {awready, wready, arready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({awready, wready, arready} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_first_cycle: got %b exp 000", {awready, wready, arready});
        end
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++;
            $display("FAIL rst_mid_ready: got %b exp 111", {awready, wready, arready});
        end
        // The W accepted before reset must be gone: AW alone cannot commit.
        awaddr = 4'h8; awvalid = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bvalid !== 0 || reg_wr_pulse !== 0) begin
                bad++;
                $display("FAIL rst_mid_w_dropped%0d: got b=%b pulse=%b exp 0 0000", i, bvalid, reg_wr_pulse);
            end
            @(posedge clk); #1;
        end
        wdata = 32'h0000BEEF; wstrb = 4'b0011; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        model_write(4'h8, 32'h0000BEEF, 4'b0011);
        total++;
        if (bvalid !== 1 || reg_wr_pulse !== 4'b0100) begin
            bad++;
            $display("FAIL rst_mid_commit: got b=%b pulse=%b exp 1 0100", bvalid, reg_wr_pulse);
        end
        @(posedge clk); #1;
        bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model[i]);
            axi_read(4'(i * 4), 0, "rst_mid_rd");
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_strobe();
        test_backpressure();
        test_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
